// File: rtl/config_pkg.sv
// config_pkg: shared CSR op encoding and timer register layout
package config_pkg;
  localparam logic [11:0] TimerAddr = 12'h400;
  localparam int TimerWidth = 16;
  localparam int TimerPreWith = 4;
  localparam int TimerTWidth = TimerWidth + TimerPreWith;
  typedef logic [TimerWidth-1:0] TimerWidthT;
  typedef logic [TimerPreWith-1:0] TimerPresWidthT;
  typedef struct packed {
    TimerWidthT counter_top;
    TimerPresWidthT prescaler;
  } TimerT;
  typedef enum logic [1:0] {NONE = 2'b00, RW = 2'b01, RS = 2'b10, RC = 2'b11} CsrOpT;
endpackage

// File: rtl/timer_prescaler.sv
// timer_prescaler: divides the clock by 2^prescaler, one tick per period
module timer_prescaler #(
  parameter int PresWidth = 4,
  parameter int PresCntWidth = (1 << PresWidth) - 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clear,
  input  logic [PresWidth-1:0] prescaler,
  output logic                 tick
);
  logic [PresCntWidth-1:0] pc;
  logic [PresCntWidth-1:0] lim;
  // low 'prescaler' bits set; a shift of the full width leaves all ones
  assign lim = ~({PresCntWidth{1'b1}} << prescaler);
  assign tick = pc == lim;
  always_ff @(posedge clk or posedge reset)
    if (reset) pc <= '0;
    else pc <= (clear || tick) ? '0 : pc + 1'b1;
endmodule

// File: rtl/timer_periph.sv
// timer_periph: CSR-configured interval timer raising a one-cycle irq per period
module timer_periph
  import config_pkg::*;
#(
  parameter logic [11:0] Addr = TimerAddr
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        csr_enable,
  input  logic [11:0] csr_addr,
  input  logic [1:0]  csr_op,
  input  logic [31:0] csr_wdata,
  output logic [31:0] csr_rdata,
  output logic        timer_irq
);
  TimerT reg_q;
  TimerWidthT cnt;
  logic [TimerTWidth-1:0] wd, nxt;
  logic hit, wr, en, tick, wrap;
  assign hit = csr_enable && csr_addr == Addr;
  assign wd = csr_wdata[TimerTWidth-1:0];
  assign wr = hit && (csr_op == RW || (csr_op != NONE && |csr_wdata));
  assign nxt = csr_op == RW ? wd : csr_op == RS ? reg_q | wd : reg_q & ~wd;
  assign csr_rdata = hit ? {{(32-TimerTWidth){1'b0}}, reg_q} : '0;
  assign en = reg_q.counter_top != '0;
  assign wrap = cnt == reg_q.counter_top;
  timer_prescaler #(.PresWidth(TimerPreWith)) u_pre (
    .clk(clk),
    .reset(reset),
    .clear(wr || !en),
    .prescaler(reg_q.prescaler),
    .tick(tick)
  );
  // a write restarts the period and suppresses a coincident wrap
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      reg_q <= '0;
      cnt <= '0;
      timer_irq <= 1'b0;
    end else begin
      if (wr) reg_q <= nxt;
      cnt <= (wr || !en) ? '0 : !tick ? cnt : wrap ? '0 : cnt + 1'b1;
      timer_irq <= tick && wrap && en && !wr;
    end
endmodule
